// File: rtl/exhaustive_stim_checker.sv
// exhaustive_stim_checker: walks every input vector through a DUT and a reference, counting output mismatches
module exhaustive_stim_checker #(
    parameter int IN_W         = 4,
    parameter int OUT_W        = 4,
    parameter int RESET_CYCLES = 3,
    parameter int LATENCY      = 0,
    parameter int ERR_W        = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [OUT_W-1:0] i_dut_out,
    input  logic [OUT_W-1:0] i_ref_out,
    output logic             o_dut_reset,
    output logic [IN_W-1:0]  o_stim,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_count,
    output logic             o_first_fail_valid,
    output logic [IN_W-1:0]  o_first_fail_vec
);
    localparam int CMAX = RESET_CYCLES > LATENCY + 1 ? RESET_CYCLES : LATENCY + 1;
    localparam int CW   = $clog2(CMAX + 1);
    typedef enum logic [1:0] {IDLE, DUT_RST, APPLY, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IN_W-1:0]  stim_q, stim_d, ffvec_q, ffvec_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ffv_q, ffv_d, pass_q, pass_d, dut_rst_q, dut_rst_d;
    logic             busy, last, mismatch;
    // next-state: start from idle/done, abort wins over compare, cnt times reset length and vector slots
    always_comb begin
        busy      = state_q == DUT_RST || state_q == APPLY;
        last      = state_q == APPLY && cnt_q == CW'(LATENCY);
        mismatch  = last && i_dut_out != i_ref_out;
        state_d   = state_q;
        cnt_d     = cnt_q;
        stim_d    = stim_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvec_d   = ffvec_q;
        pass_d    = pass_q;
        if (!busy && i_start) begin
            state_d = DUT_RST;
            cnt_d   = '0;
            stim_d  = '0;
            err_d   = '0;
            ffv_d   = 1'b0;
            ffvec_d = '0;
            pass_d  = 1'b0;
        end else if (busy && i_abort) begin
            state_d = DONE;
            pass_d  = 1'b0;
        end else if (state_q == DUT_RST) begin
            state_d = cnt_q == CW'(RESET_CYCLES - 1) ? APPLY : DUT_RST;
            cnt_d   = cnt_q == CW'(RESET_CYCLES - 1) ? '0 : cnt_q + 1'b1;
        end else if (state_q == APPLY) begin
            err_d   = mismatch && !(&err_q) ? err_q + 1'b1 : err_q;
            ffv_d   = ffv_q || mismatch;
            ffvec_d = mismatch && !ffv_q ? stim_q : ffvec_q;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            stim_d  = last && !(&stim_q) ? stim_q + 1'b1 : stim_q;
            state_d = last && (&stim_q) ? DONE : APPLY;
            pass_d  = !mismatch && err_q == '0;
        end
        dut_rst_d = state_d == DUT_RST;
    end
    // state and result registers; reset holds the DUT in reset and clears all results
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stim_q    <= '0;
            err_q     <= '0;
            ffv_q     <= 1'b0;
            ffvec_q   <= '0;
            pass_q    <= 1'b0;
            dut_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stim_q    <= stim_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvec_q   <= ffvec_d;
            pass_q    <= pass_d;
            dut_rst_q <= dut_rst_d;
        end
    end
    assign o_dut_reset        = dut_rst_q;
    assign o_stim             = stim_q;
    assign o_busy             = busy;
    assign o_done             = state_q == DONE;
    assign o_pass             = state_q == DONE && pass_q;
    assign o_err_count        = err_q;
    assign o_first_fail_valid = ffv_q;
    assign o_first_fail_vec   = ffvec_q;
endmodule

// File: tb/tb_exhaustive_stim_checker.sv
// tb_exhaustive_stim_checker: directed scenarios on a default instance and a LATENCY=2/ERR_W=2 instance
module tb_exhaustive_stim_checker;
    logic clk = 1'b0, rst = 1'b1;
    logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic [15:0] bad0 = '0, bad1 = '0;
    logic [3:0] stim0, stim1, ref0, ref1, dut0, dut1, ffvec0, ffvec1;
    logic dr0, busy0, done0, pass0, ffv0, dr1, busy1, done1, pass1, ffv1;
    logic [7:0] err0;
    logic [1:0] err1;
    int total = 0, nbad = 0;

    always #5 clk = ~clk;

    assign ref0 = ~stim0;
    assign dut0 = ref0 ^ {3'b000, bad0[stim0]};
    assign ref1 = stim1 + 4'd3;
    assign dut1 = ref1 ^ {bad1[stim1], 3'b000};

    exhaustive_stim_checker u0 (
        .i_clk(clk), .i_reset(rst), .i_start(start0), .i_abort(abort0),
        .i_dut_out(dut0), .i_ref_out(ref0), .o_dut_reset(dr0), .o_stim(stim0),
        .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_count(err0),
        .o_first_fail_valid(ffv0), .o_first_fail_vec(ffvec0));

    exhaustive_stim_checker #(.LATENCY(2), .ERR_W(2)) u1 (
        .i_clk(clk), .i_reset(rst), .i_start(start1), .i_abort(abort1),
        .i_dut_out(dut1), .i_ref_out(ref1), .o_dut_reset(dr1), .o_stim(stim1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_count(err1),
        .o_first_fail_valid(ffv1), .o_first_fail_vec(ffvec1));

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b1; abort0 = 1'b1; start1 = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({dr0, stim0, busy0, done0, pass0, err0, ffv0, ffvec0} !== {1'b1, 4'd0, 3'b000, 8'd0, 1'b0, 4'd0}) begin
            nbad++;
            $display("FAIL reset_u0 got=%h want=%h", {dr0, stim0, busy0, done0, pass0, err0, ffv0, ffvec0}, {1'b1, 4'd0, 3'b000, 8'd0, 1'b0, 4'd0});
        end
        total++;
        if ({dr1, stim1, busy1, done1, pass1, err1, ffv1, ffvec1} !== {1'b1, 4'd0, 3'b000, 2'd0, 1'b0, 4'd0}) begin
            nbad++;
            $display("FAIL reset_u1 got=%h want=%h", {dr1, stim1, busy1, done1, pass1, err1, ffv1, ffvec1}, {1'b1, 4'd0, 3'b000, 2'd0, 1'b0, 4'd0});
        end
        rst = 1'b0; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        total++;
        if ({dr0, busy0, done0} !== 3'b000) begin
            nbad++;
            $display("FAIL idle_after_reset got=%b want=000", {dr0, busy0, done0});
        end
    endtask

    task automatic test_full_run(input logic with_abort);
        logic [3:0] es;
        start0 = 1'b1; abort0 = with_abort;
        @(negedge clk);
        start0 = 1'b0; abort0 = 1'b0;
        for (int k = 0; k <= 19; k++) begin
            es = k < 3 ? 4'd0 : (k < 19 ? 4'(k - 3) : 4'd15);
            total++;
            if ({dr0, busy0, done0, stim0} !== {k < 3, k < 19, k == 19, es}) begin
                nbad++;
                $display("FAIL full_run_k%0d got=%b want=%b", k, {dr0, busy0, done0, stim0}, {k < 3, k < 19, k == 19, es});
            end
            if (k == 0) begin
                total++;
                if ({err0, ffv0, pass0} !== 10'd0) begin
                    nbad++;
                    $display("FAIL full_run_cleared got=%h want=0", {err0, ffv0, pass0});
                end
            end
            if (k < 19) @(negedge clk);
        end
        total++;
        if ({pass0, err0, ffv0} !== {1'b1, 8'd0, 1'b0}) begin
            nbad++;
            $display("FAIL full_run_result got=%h want=%h", {pass0, err0, ffv0}, {1'b1, 8'd0, 1'b0});
        end
    endtask

    task automatic test_latency();
        logic [3:0] es;
        bad1 = 16'h0220;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k <= 51; k++) begin
            es = k < 3 ? 4'd0 : (k < 51 ? 4'((k - 3) / 3) : 4'd15);
            total++;
            if ({dr1, busy1, done1, stim1} !== {k < 3, k < 51, k == 51, es}) begin
                nbad++;
                $display("FAIL latency_k%0d got=%b want=%b", k, {dr1, busy1, done1, stim1}, {k < 3, k < 51, k == 51, es});
            end
            if (k < 51) @(negedge clk);
        end
        total++;
        if ({err1, ffv1, ffvec1, pass1} !== {2'd2, 1'b1, 4'd5, 1'b0}) begin
            nbad++;
            $display("FAIL latency_result got=%h want=%h", {err1, ffv1, ffvec1, pass1}, {2'd2, 1'b1, 4'd5, 1'b0});
        end
    endtask

    task automatic test_saturate();
        bad1 = 16'hFFFF;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (51) @(negedge clk);
        total++;
        if ({done1, err1, ffv1, ffvec1, pass1} !== {1'b1, 2'd3, 1'b1, 4'd0, 1'b0}) begin
            nbad++;
            $display("FAIL saturate got=%h want=%h", {done1, err1, ffv1, ffvec1, pass1}, {1'b1, 2'd3, 1'b1, 4'd0, 1'b0});
        end
    endtask

    task automatic test_abort();
        bad0 = 16'h0088;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if ({stim0, err0} !== {4'd7, 8'd1}) begin
            nbad++;
            $display("FAIL abort_pre got=%h want=%h", {stim0, err0}, {4'd7, 8'd1});
        end
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        total++;
        if ({done0, busy0, pass0, err0, stim0, ffvec0} !== {3'b100, 8'd1, 4'd7, 4'd3}) begin
            nbad++;
            $display("FAIL abort_done got=%h want=%h", {done0, busy0, pass0, err0, stim0, ffvec0}, {3'b100, 8'd1, 4'd7, 4'd3});
        end
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        @(negedge clk);
        total++;
        if ({done0, err0, stim0} !== {1'b1, 8'd1, 4'd7}) begin
            nbad++;
            $display("FAIL abort_idle got=%h want=%h", {done0, err0, stim0}, {1'b1, 8'd1, 4'd7});
        end
    endtask

    task automatic test_back_to_back();
        bad0 = '0;
        test_full_run(1'b1);
        test_full_run(1'b0);
    endtask

    task automatic test_mid_reset();
        bad0 = 16'h0004;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (7) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        total++;
        if ({stim0, busy0, dr0} !== {4'd5, 1'b1, 1'b0}) begin
            nbad++;
            $display("FAIL start_ignored got=%h want=%h", {stim0, busy0, dr0}, {4'd5, 1'b1, 1'b0});
        end
        repeat (5) @(negedge clk);
        total++;
        if ({stim0, err0} !== {4'd10, 8'd1}) begin
            nbad++;
            $display("FAIL mid_pre got=%h want=%h", {stim0, err0}, {4'd10, 8'd1});
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({dr0, stim0, busy0, done0, pass0, err0, ffv0, ffvec0} !== {1'b1, 4'd0, 3'b000, 8'd0, 1'b0, 4'd0}) begin
            nbad++;
            $display("FAIL mid_reset got=%h want=%h", {dr0, stim0, busy0, done0, pass0, err0, ffv0, ffvec0}, {1'b1, 4'd0, 3'b000, 8'd0, 1'b0, 4'd0});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({dr0, busy0, done0} !== 3'b000) begin
            nbad++;
            $display("FAIL mid_release got=%b want=000", {dr0, busy0, done0});
        end
        bad0 = '0;
        test_full_run(1'b0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_run(1'b0);
        test_latency();
        test_saturate();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end
endmodule
